// File: rtl/fetch_pkg.sv
// Shared fetch definitions.
// Provides the instruction size in bytes and an address alignment helper. The
// branch unit uses the same helpers to form jump targets, so both agree on
// which address bits are ignored.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned MaxAddrWidth = 64;

    // Mask that clears the byte-offset bits of an instruction address.
    function automatic logic [MaxAddrWidth-1:0] align_mask();
        return ~(MaxAddrWidth'(INSTR_BYTES - 1));
    endfunction

    function automatic logic [MaxAddrWidth-1:0] word_align(input logic [MaxAddrWidth-1:0] addr);
        return addr & align_mask();
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: synchronous FIFO of DEPTH entries, each WIDTH bits.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head entry
//   flush_i        empty the queue. This overrides push_i and pop_i.
//   count_o        number of valid entries, 0..DEPTH
//   head_o         head entry. It is only meaningful when count_o != 0.
// DEPTH must be a power of two, so the pointers wrap naturally.
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CntW-1:0]  count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // A simultaneous push and pop leaves the count unchanged.
            if (push_i && !pop_i) begin
                count_d = count_q + CntW'(1);
            end else if (!push_i && pop_i) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array has no reset. Entries are only read after they are written.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction fetch stage with a prefetch queue.
// The unit issues sequential reads to a synchronous instruction memory. Each
// returned word is queued together with its PC, and the head entry is handed
// to decode over a valid/ready handshake. A redirect flushes the queue, squashes
// the read in flight and restarts fetch at the aligned target on the next cycle.
// Ports:
//   Clk, Reset      clock and asynchronous active-low reset
//   ImemRead        read request this cycle
//   ImemAddr        read address
//   ImemData        read data, one cycle after ImemRead
//   Redirect        control-flow change this cycle
//   RedirectPC      new fetch address. Bits [1:0] are ignored.
//   OutValid        head entry valid towards decode
//   OutReady        decode accepts the head entry
//   OutInstr        head instruction
//   OutPC           head instruction address
//   OutPCNext4      head instruction address + 4
module instruction_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic                   ImemRead,
    output logic [ADDR_WIDTH-1:0]  ImemAddr,
    input  logic [INSTR_WIDTH-1:0] ImemData,
    input  logic                   Redirect,
    input  logic [ADDR_WIDTH-1:0]  RedirectPC,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [INSTR_WIDTH-1:0] OutInstr,
    output logic [ADDR_WIDTH-1:0]  OutPC,
    output logic [ADDR_WIDTH-1:0]  OutPCNext4
);

    localparam int unsigned EntryW = INSTR_WIDTH + ADDR_WIDTH;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    // Occupancy may reach DEPTH + 1 before the pop term is subtracted.
    localparam int unsigned OccW   = $clog2(DEPTH + 2);

    localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(align_mask());
    localparam logic [ADDR_WIDTH-1:0] PcStep    = ADDR_WIDTH'(INSTR_BYTES);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q;
    logic [ADDR_WIDTH-1:0]  out_pc_q;
    logic [ADDR_WIDTH-1:0]  out_pc_next4_q;

    logic [CntW-1:0]        fifo_count;
    logic [EntryW-1:0]      fifo_head;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic                   has_entry;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [OccW-1:0]        occupancy;

    assign head_instr = fifo_head[EntryW-1:ADDR_WIDTH];
    assign head_pc    = fifo_head[ADDR_WIDTH-1:0];
    assign has_entry  = (fifo_count != '0);

    // A redirect masks OutValid, so a flushed head is never accepted.
    assign OutValid = has_entry & ~Redirect;
    assign pop      = OutValid & OutReady;

    // The pop term lets issue resume in the same cycle that decode drains a full queue.
    assign occupancy = OccW'(fifo_count) + OccW'(inflight_q) - OccW'(pop);
    // Gating with Reset keeps ImemRead low while the unit is held in reset.
    assign issue     = Reset & ~Redirect & (occupancy < OccW'(DEPTH));

    // The response of a read squashed by a redirect in this cycle is dropped.
    assign push = inflight_q & ~Redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (Redirect) begin
            fetch_pc_d = RedirectPC & AlignMask;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PcStep;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // These registers mirror the head entry, so the data outputs hold their
    // last values once the queue empties.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_pc_next4_q <= '0;
        end else if (has_entry) begin
            out_instr_q    <= head_instr;
            out_pc_q       <= head_pc;
            out_pc_next4_q <= head_pc + PcStep;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_prefetch_fifo (
        .clk_i       (Clk),
        .rst_ni      (Reset),
        .push_i      (push),
        .push_data_i ({ImemData, inflight_pc_q}),
        .pop_i       (pop),
        .flush_i     (Redirect),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign ImemRead   = issue;
    assign ImemAddr   = fetch_pc_q;
    assign OutInstr   = has_entry ? head_instr : out_instr_q;
    assign OutPC      = has_entry ? head_pc : out_pc_q;
    assign OutPCNext4 = has_entry ? (head_pc + PcStep) : out_pc_next4_q;

endmodule
